crc_sig_sched: RTL
==================

# crc_sig_sched

Scheduler and sequencer for the shared 32-bit CRC/MISR signature register in the s35932 compaction path. Up to NREQ requesters each ask for a signature job of LEN words. The block grants the register to one requester at a time (round-robin), seeds it, absorbs the granted requester's words through a valid/ready stream, then reports the final signature and the requester ID. It sits between the per-channel capture logic and the signature readout, and replaces free-running compaction with job-framed compaction.

## Interface
- NREQ, 4, number of requesters (2..8)
- LENW, 8, width of job length field in words
- POLY, 32'h0001_0811, feedback taps: bit i receives s[31] when POLY[i]=1 (taps 0, 4, 11, 16)
- SEED, 32'h0000_0000, MISR value loaded at job start

Ports:
- CK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- req  in  NREQ  job request per requester; level, held until that requester's done
- len  in  NREQ*LENW  per-requester job length in words; sampled at grant
- abort  in  1  cancels the running job
- grant  out  NREQ  one-hot owner of the MISR; all-zero when idle
- data_valid  in  1  word from granted requester valid
- data_in  in  32  word to absorb
- data_ready  out  1  MISR accepts a word this cycle
- done  out  1  one-cycle pulse, job complete
- aborted  out  1  one-cycle pulse, job cancelled
- done_id  out  $clog2(NREQ)  requester of last completed or aborted job
- sig_out  out  32  signature of last completed job; held until the next done

## Operation
- FSM has 3 states, IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - On any req bit, pick the winner round-robin, starting at the index after the last winner. After reset the pointer is 0, so req[0] has highest priority.
  - Register a one-hot grant, load cnt = len[winner], load MISR = SEED.
  - If len[winner] = 0, go to DONE. Otherwise go to RUN.
- RUN:
  - data_ready = 1.
  - Each data_valid & data_ready beat updates the MISR and decrements cnt.
  - The beat that takes cnt from 1 to 0 moves the FSM to DONE.
- DONE:
  - done = 1.
  - sig_out <= MISR, done_id <= winner.
  - grant clears, the pointer advances past the winner, and the FSM returns to IDLE.
- MISR update (arithmetic modulo 2, data bits only in the XOR):
  - next[0] = s[31]^d[0]
  - next[i] = s[i-1]^d[i]^(POLY[i]&s[31]) for i = 1..31
- abort in RUN:
  - The FSM goes to IDLE next cycle and aborted pulses.
  - done_id is updated. sig_out and done are not.
  - The pointer advances past the aborted requester.
  - abort in IDLE or DONE is ignored.
- A req that deasserts during RUN does not end the job. Only cnt or abort ends it.
- A req that stays high after done is treated as a new job in the next IDLE cycle.
- Reset values: grant 0, data_ready 0, done 0, aborted 0, done_id 0, sig_out 0, MISR 0, cnt 0, pointer 0.
- An asynchronous RESET mid-job discards the job immediately, with no done or aborted pulse.

## Timing
- req sampled in IDLE at edge t: grant and data_ready are high from t+1.
- First word is accepted in cycle t+1 at the earliest.
- A job of N ≥ 1 words with no stalls: done at cycle t+N+1, back in IDLE at t+N+2.
- A len = 0 job: done at t+1.
- Back-to-back jobs have a minimum of 1 IDLE cycle between done and the next grant.
- sig_out and done_id are registered and valid in the same cycle as done.
- data_valid while data_ready = 0 is ignored; no word is consumed.

## Configuration
- CRC_SIG_GOLDEN_CHECK_EN:
  - Defined: adds input golden_in (32) and output sig_fail (1).
  - sig_fail is registered together with done as (MISR != golden_in) and held until the next done.
  - sig_fail resets to 0 and is not updated by abort.
  - Undefined: neither port exists and there is no compare logic.

## Structure
- Package crc_sig_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the default POLY and SEED constants
  - the function misr_next(s, d, poly)
- Sub-module crc_sig_misr: the 32-bit register with load-seed and update-enable. Arbitration, counting and the FSM stay in crc_sig_sched.

## Test plan
- Single-word signature: SEED 0, req[1] with len 1, word 0x0000_0001 → done 2 cycles after req sampled, sig_out 0x0000_0001, done_id 1.
- Feedback check: len 2, words 0x8000_0000 then 0x0000_0000 → sig_out 0x0001_0811.
- Round-robin: req = 4'b1111 held, each len 1 → grants in order 0, 1, 2, 3, 0; one IDLE cycle between done and the next grant.
- Zero-length and stalls:
  - len 0 → done at t+1 with sig_out = SEED.
  - len 3 with data_valid low for 2 cycles mid-job → done delayed by exactly 2 cycles, same signature.
- Abort and reset:
  - abort after the 2nd of 4 words → aborted pulse, sig_out unchanged, next requester granted.
  - RESET low mid-RUN → all outputs 0 immediately.
- With CRC_SIG_GOLDEN_CHECK_EN: golden_in 0x0001_0811 on the feedback vector → sig_fail 0; golden_in 0 → sig_fail 1.

Source files
------------

// File: rtl/crc_sig_pkg.sv
// Shared types, default constants and MISR step function for the signature scheduler.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package crc_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] POLY_DEF = 32'h0001_0811;
  localparam logic [31:0] SEED_DEF = 32'h0000_0000;

  // One MISR step: shift left, fold s[31] into the tap bits, XOR the data word in.
  function automatic logic [31:0] misr_next(input logic [31:0] s,
                                            input logic [31:0] d,
                                            input logic [31:0] poly);
    logic [31:0] n;
    n[0] = s[31] ^ d[0];
    for (int i = 1; i < 32; i++) begin
      n[i] = s[i-1] ^ d[i] ^ (poly[i] & s[31]);
    end
    return n;
  endfunction

endpackage

// File: rtl/crc_sig_sched_if.sv
// Bundle of job request, data stream and result signals of the signature scheduler.
// Latency: not applicable (wiring only); optional golden compare ports under CRC_SIG_GOLDEN_CHECK_EN.
// Backpressure: data_valid/data_ready stream, req held by the requester until its done.
interface crc_sig_sched_if #(
  parameter int NREQ = 4,
  parameter int LENW = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ*LENW-1:0]    len;
  logic                    abort;
  logic [NREQ-1:0]         grant;
  logic                    data_valid;
  logic [31:0]             data_in;
  logic                    data_ready;
  logic                    done;
  logic                    aborted;
  logic [$clog2(NREQ)-1:0] done_id;
  logic [31:0]             sig_out;
`ifdef CRC_SIG_GOLDEN_CHECK_EN
  logic [31:0]             golden_in;
  logic                    sig_fail;

  modport master (
    output req, len, abort, data_valid, data_in, golden_in,
    input  grant, data_ready, done, aborted, done_id, sig_out, sig_fail
  );
  modport slave (
    input  req, len, abort, data_valid, data_in, golden_in,
    output grant, data_ready, done, aborted, done_id, sig_out, sig_fail
  );
`else
  modport master (
    output req, len, abort, data_valid, data_in,
    input  grant, data_ready, done, aborted, done_id, sig_out
  );
  modport slave (
    input  req, len, abort, data_valid, data_in,
    output grant, data_ready, done, aborted, done_id, sig_out
  );
`endif
endinterface

// File: rtl/crc_sig_misr.sv
// 32-bit MISR register with seed load and per-word update enable.
// Latency: new value visible one cycle after load/update; sig_d_o shows that value in advance.
// Backpressure: none; the caller gates upd_i with its own handshake.
module crc_sig_misr
  import crc_sig_pkg::*;
#(
  parameter logic [31:0] POLY = POLY_DEF
) (
  input  logic        CK,
  input  logic        RESET,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        upd_i,
  input  logic [31:0] dat_i,
  output logic [31:0] sig_d_o
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  // Seed load wins over an update in the same cycle.
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = seed_i;
    end else if (upd_i) begin
      sig_d = misr_next(sig_q, dat_i, POLY);
    end
  end

  // Signature register.
  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  // The scheduler captures the final signature on the same edge as the last word.
  assign sig_d_o = sig_d;

endmodule

// File: rtl/crc_sig_sched.sv
// Round-robin job scheduler framing compaction into the shared MISR; optional golden compare via CRC_SIG_GOLDEN_CHECK_EN.
// Latency: grant 1 cycle after req; done N+1 cycles after req for N unstalled words; at least 1 idle cycle between jobs.
// Backpressure: data_ready high only while a job runs; data_valid without data_ready is ignored.
module crc_sig_sched
  import crc_sig_pkg::*;
#(
  parameter int          NREQ = 4,
  parameter int          LENW = 8,
  parameter logic [31:0] POLY = POLY_DEF,
  parameter logic [31:0] SEED = SEED_DEF
) (
  input logic            CK,
  input logic            RESET,
  crc_sig_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic              rdy_q;
  logic              done_q;
  logic              aborted_q;
  logic [IDW-1:0]    done_id_q;
  logic [IDW-1:0]    win_q;
  logic [IDW-1:0]    ptr_q;
  logic [LENW-1:0]   cnt_q;
  logic [31:0]       sig_out_q;

  logic              any_req;
  logic [IDW-1:0]    pick;
  logic [LENW-1:0]   pick_len;
  logic              beat;
  logic              misr_load;
  logic              misr_upd;
  logic              enter_done;
  logic [IDW-1:0]    done_win;
  logic [31:0]       misr_d;

  // Index following w, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] adv(input logic [IDW-1:0] w);
    return (int'(w) + 1 >= NREQ) ? '0 : IDW'(int'(w) + 1);
  endfunction

  // Round-robin pick: scan from the pointer upward, first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    pick    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req[idx]) begin
        any_req = 1'b1;
        pick    = IDW'(idx);
      end
    end
  end

  assign pick_len   = bus.len[pick*LENW +: LENW];
  assign beat       = rdy_q & bus.data_valid;
  assign misr_load  = (state_q == IDLE) & any_req;
  assign misr_upd   = beat & ~bus.abort;
  assign enter_done = (misr_load && (pick_len == '0)) ||
                      (misr_upd && (cnt_q == LENW'(1)));
  assign done_win   = (state_q == IDLE) ? pick : win_q;

  crc_sig_misr #(.POLY(POLY)) u_misr (
    .CK      (CK),
    .RESET   (RESET),
    .load_i  (misr_load),
    .seed_i  (SEED),
    .upd_i   (misr_upd),
    .dat_i   (bus.data_in),
    .sig_d_o (misr_d)
  );

  // Job FSM with registered grant, ready, done/aborted pulses and result capture.
  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_id_q <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sig_out_q <= '0;
    end else begin
      done_q    <= enter_done;
      aborted_q <= 1'b0;
      // Result is captured on entry to DONE so it is valid alongside done.
      if (enter_done) begin
        sig_out_q <= misr_d;
        done_id_q <= done_win;
        ptr_q     <= adv(done_win);
      end
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= NREQ'(1) << pick;
            win_q   <= pick;
            cnt_q   <= pick_len;
            if (pick_len == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              rdy_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            grant_q   <= '0;
            aborted_q <= 1'b1;
            done_id_q <= win_q;
            ptr_q     <= adv(win_q);
          end else if (beat) begin
            cnt_q <= cnt_q - LENW'(1);
            if (cnt_q == LENW'(1)) begin
              state_q <= DONE;
              rdy_q   <= 1'b0;
            end
          end
        end
        DONE: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CRC_SIG_GOLDEN_CHECK_EN
  logic sig_fail_q;

  // Golden compare result follows done only; aborts leave it untouched.
  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      sig_fail_q <= 1'b0;
    end else if (enter_done) begin
      sig_fail_q <= (misr_d != bus.golden_in);
    end
  end

  assign bus.sig_fail = sig_fail_q;
`endif

  assign bus.grant      = grant_q;
  assign bus.data_ready = rdy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.done_id    = done_id_q;
  assign bus.sig_out    = sig_out_q;

endmodule
